down_counter_timer: RTL and testbench

- Loadable synchronous n-bit down-counter/timer; the count-down counterpart to the team's up-counter with rollover.
- Software/FSM logic loads a start value. The block decrements on enabled clocks and pulses Terminal when the count expires.
- Supports one-shot mode and auto-reload (periodic tick generator) mode.
- Sits beside the up-counter in timing/sequencing datapaths, e.g. timeouts, prescalers, delay generation.

---
 rtl/down_counter_timer_if.sv | 22 ++
 rtl/down_counter_timer.sv | 60 ++++++
 tb/tb_down_counter_timer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control/status bundle for the loadable down-counter timer
interface down_counter_timer_if #(
  parameter int n = 4
);
  logic         Load;
  logic [n-1:0] LoadValue;
  logic         Enable;
  logic         Mode;
  logic [n-1:0] Q;
  logic         Terminal;
  logic         Busy;

  modport master (
    output Load, LoadValue, Enable, Mode,
    input  Q, Terminal, Busy
  );

  modport slave (
    input  Load, LoadValue, Enable, Mode,
    output Q, Terminal, Busy
  );
endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable n-bit down-counter with one-shot and auto-reload modes
module down_counter_timer #(
  parameter int n = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  down_counter_timer_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_next;
  logic [n-1:0] q, q_next;
  logic [n-1:0] reload, reload_next;
  logic         terminal, terminal_next;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      q        <= '0;
      reload   <= '0;
      terminal <= 1'b0;
    end else begin
      state    <= state_next;
      q        <= q_next;
      reload   <= reload_next;
      terminal <= terminal_next;
    end
  end

  // Load outranks expiry, so a load on the expiry edge swallows that pulse.
  always_comb begin
    state_next    = state;
    q_next        = q;
    reload_next   = reload;
    terminal_next = 1'b0;
    if (bus.Load) begin
      reload_next = bus.LoadValue;
      q_next      = bus.LoadValue;
      state_next  = (bus.LoadValue != '0) ? RUN : IDLE;
    end else if (state == RUN && bus.Enable) begin
      if (q == n'(1)) begin
        terminal_next = 1'b1;
        if (bus.Mode) begin
          q_next = reload;
        end else begin
          q_next     = '0;
          state_next = IDLE;
        end
      end else begin
        q_next = q - n'(1);
      end
    end
  end

  assign bus.Q        = q;
  assign bus.Terminal = terminal;
  assign bus.Busy     = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - directed self-checking bench for down_counter_timer
`timescale 1ns/1ps
module tb_down_counter_timer;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  down_counter_timer_if #(.n(4)) bus ();

  down_counter_timer #(.n(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int gate_en [7] = '{1, 0, 0, 1, 1, 0, 1};
  int gate_q  [7] = '{3, 3, 3, 2, 1, 1, 0};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_load(input int value, input logic mode, input logic en);
    bus.Load      = 1'b1;
    bus.LoadValue = value[3:0];
    bus.Mode      = mode;
    bus.Enable    = en;
    tick();
    bus.Load      = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Load = 1'b0; bus.LoadValue = '0; bus.Enable = 1'b0; bus.Mode = 1'b0;
    #1;
    checks++;
    if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", bus.Q, bus.Terminal, bus.Busy);
    end
    tick();
    Reset = 1'b0;
    bus.Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_load[%0d]: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", i, bus.Q, bus.Terminal, bus.Busy);
      end
    end
  endtask

  task automatic test_one_shot();
    do_load(5, 1'b0, 1'b1);
    checks++;
    if (bus.Q !== 4'd5 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL one_shot_load: got Q=%0d T=%b B=%b expected Q=5 T=0 B=1", bus.Q, bus.Terminal, bus.Busy);
    end
    for (int i = 4; i >= 0; i--) begin
      tick();
      checks++;
      if (bus.Q !== 4'(i) || bus.Terminal !== (i == 0) || bus.Busy !== (i != 0)) begin
        errors++;
        $display("FAIL one_shot_step[%0d]: got Q=%0d T=%b B=%b expected Q=%0d T=%b B=%b",
                 i, bus.Q, bus.Terminal, bus.Busy, i, (i == 0), (i != 0));
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_hold[%0d]: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", i, bus.Q, bus.Terminal, bus.Busy);
      end
    end
  endtask

  task automatic test_auto_reload();
    int pulses;
    pulses = 0;
    do_load(3, 1'b1, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.Terminal === 1'b1) pulses++;
      checks++;
      if (bus.Q !== 4'(3 - (k % 3)) || bus.Terminal !== (k % 3 == 0) || bus.Busy !== 1'b1) begin
        errors++;
        $display("FAIL auto_reload[%0d]: got Q=%0d T=%b B=%b expected Q=%0d T=%b B=1",
                 k, bus.Q, bus.Terminal, bus.Busy, 3 - (k % 3), (k % 3 == 0));
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL auto_reload_pulses: got %0d expected 4", pulses);
    end
  endtask

  task automatic test_enable_gating();
    int pulses;
    pulses = 0;
    do_load(4, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      bus.Enable = gate_en[k][0];
      tick();
      if (bus.Terminal === 1'b1) pulses++;
      checks++;
      if (bus.Q !== 4'(gate_q[k]) || bus.Terminal !== (k == 6)) begin
        errors++;
        $display("FAIL enable_gating[%0d]: got Q=%0d T=%b expected Q=%0d T=%b",
                 k, bus.Q, bus.Terminal, gate_q[k], (k == 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL enable_gating_pulses: got %0d expected 1", pulses);
    end
    bus.Enable = 1'b1;
  endtask

  task automatic test_load_collision();
    do_load(3, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.Q !== 4'd1) begin
      errors++;
      $display("FAIL collision_setup: got Q=%0d expected 1", bus.Q);
    end
    do_load(6, 1'b1, 1'b1);
    checks++;
    if (bus.Q !== 4'd6 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL collision_reload: got Q=%0d T=%b B=%b expected Q=6 T=0 B=1", bus.Q, bus.Terminal, bus.Busy);
    end
    tick();
    do_load(0, 1'b1, 1'b1);
    checks++;
    if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_load_zero: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", bus.Q, bus.Terminal, bus.Busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL load_zero_hold[%0d]: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", i, bus.Q, bus.Terminal, bus.Busy);
      end
    end
  endtask

  task automatic test_max_period();
    int pulses;
    pulses = 0;
    do_load(15, 1'b1, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (bus.Terminal === 1'b1) pulses++;
      checks++;
      if (bus.Q !== 4'(15 - (k % 15)) || bus.Terminal !== (k % 15 == 0)) begin
        errors++;
        $display("FAIL max_period[%0d]: got Q=%0d T=%b expected Q=%0d T=%b",
                 k, bus.Q, bus.Terminal, 15 - (k % 15), (k % 15 == 0));
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL max_period_pulses: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_reload_one();
    do_load(1, 1'b1, 1'b1);
    checks++;
    if (bus.Q !== 4'd1 || bus.Terminal !== 1'b0) begin
      errors++;
      $display("FAIL reload_one_load: got Q=%0d T=%b expected Q=1 T=0", bus.Q, bus.Terminal);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.Q !== 4'd1 || bus.Terminal !== 1'b1 || bus.Busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_one[%0d]: got Q=%0d T=%b B=%b expected Q=1 T=1 B=1", k, bus.Q, bus.Terminal, bus.Busy);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_load(10, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    checks++;
    if (bus.Q !== 4'd7 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_count_setup: got Q=%0d B=%b expected Q=7 B=1", bus.Q, bus.Busy);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", bus.Q, bus.Terminal, bus.Busy);
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.Q !== 4'd0 || bus.Terminal !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: got Q=%0d T=%b B=%b expected Q=0 T=0 B=0", i, bus.Q, bus.Terminal, bus.Busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_load_collision();
    test_max_period();
    test_reload_one();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
